// File: rtl/mlsu_pkg.sv
// -----------------------------------------------------------------------------
// mlsu_pkg
//   Shared types and helpers for the MLSU request arbiter.
//   - mlsu_arb_state_e : arbiter FSM states (IDLE, HOLD)
//   - rr_next_idx      : round-robin wrap-around increment
// -----------------------------------------------------------------------------
package mlsu_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } mlsu_arb_state_e;

  // (idx + 1) mod n, for idx < n.
  function automatic int unsigned rr_next_idx(input int unsigned idx,
                                              input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/mlsu_rr_picker.sv
// -----------------------------------------------------------------------------
// mlsu_rr_picker
//   Combinational round-robin priority scan. Starting at ptr and wrapping
//   upward, returns the first index whose elig bit is set.
//
// Ports:
//   elig  in  NrReq  eligible requesters
//   ptr   in  IdW    index with highest priority this cycle
//   valid out 1      at least one requester is eligible
//   idx   out IdW    winning index (0 when valid is low)
// -----------------------------------------------------------------------------
module mlsu_rr_picker #(
  parameter int unsigned NrReq = 2,
  parameter int unsigned IdW   = (NrReq > 1) ? $clog2(NrReq) : 1
) (
  input  logic [NrReq-1:0] elig,
  input  logic [IdW-1:0]   ptr,
  output logic             valid,
  output logic [IdW-1:0]   idx
);

  // Candidate gi is the requester at distance gi from ptr (with wrap), so
  // candidate 0 has the highest priority.
  logic [IdW-1:0]   cand_idx [NrReq];
  logic [NrReq-1:0] cand_elig;

  for (genvar gi = 0; gi < NrReq; gi++) begin : g_cand
    always_comb begin : p_wrap
      int unsigned sum;
      sum = 32'(ptr) + 32'(gi);
      if (sum >= NrReq) begin
        sum = sum - NrReq;
      end
      cand_idx[gi] = IdW'(sum);
    end
    assign cand_elig[gi] = elig[cand_idx[gi]];
  end

  // Scan from the lowest priority upward so the closest candidate wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = int'(NrReq) - 1; k >= 0; k--) begin
      if (cand_elig[k]) begin
        valid = 1'b1;
        idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/mlsu_req_arbiter.sv
// -----------------------------------------------------------------------------
// mlsu_req_arbiter
//   Round-robin arbiter sharing the MLSU control-machine request port among
//   NrReq load/store issue sources. A grant that is not accepted immediately
//   is locked until the control machine takes it, so valid/payload/id stay
//   stable downstream. Outstanding stores are counted and reported.
//
// Build option:
//   MLSU_ARB_LDST_ORDER_EN  defined: loads are held back while any store is
//                           outstanding. Undefined: only the store limit
//                           MaxStOutst gates issue.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_valid_i[NrReq]    per-requester valid
//   req_ready_o[NrReq]    per-requester ready (handshake on granted source)
//   req_i[NrReq]          per-requester payload
//   req_is_store_i[NrReq] per-requester store flag
//   mlsu_req_valid_o      valid to control machine
//   mlsu_req_ready_i      ready from control machine
//   mlsu_req_o            granted payload
//   mlsu_req_id_o         granted requester index
//   st_done_i             one pulse per completed store
//   st_pending_o          at least one store outstanding
//   st_outst_cnt_o        outstanding store count
// -----------------------------------------------------------------------------
module mlsu_req_arbiter
  import mlsu_pkg::*;
#(
  parameter int unsigned NrReq      = 2,
  parameter int unsigned MaxStOutst = 4,
  parameter type         mlsu_init_req_t = logic,
  parameter int unsigned IdW        = (NrReq > 1) ? $clog2(NrReq) : 1,
  parameter int unsigned CntW       = $clog2(MaxStOutst + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NrReq-1:0]     req_valid_i,
  output logic [NrReq-1:0]     req_ready_o,
  input  mlsu_init_req_t       req_i [NrReq],
  input  logic [NrReq-1:0]     req_is_store_i,
  output logic                 mlsu_req_valid_o,
  input  logic                 mlsu_req_ready_i,
  output mlsu_init_req_t       mlsu_req_o,
  output logic [IdW-1:0]       mlsu_req_id_o,
  input  logic                 st_done_i,
  output logic                 st_pending_o,
  output logic [CntW-1:0]      st_outst_cnt_o
);

  localparam logic [CntW-1:0] MAX_CNT = CntW'(MaxStOutst);

  mlsu_arb_state_e state_reg, state_next;
  logic [IdW-1:0]  ptr_reg,   ptr_next;
  logic [IdW-1:0]  lock_reg,  lock_next;
  logic [CntW-1:0] cnt_reg,   cnt_next;

  logic [NrReq-1:0] elig;
  logic             store_blk;
  logic             load_blk;
  logic             pick_valid;
  logic [IdW-1:0]   winner;
  logic             grant_vld;
  logic [IdW-1:0]   grant_id;
  logic             handshake;
  logic             st_inc;
  logic             st_dec;

  // ---------------------------------------------------------------------------
  // Eligibility (only consulted in IDLE; a locked grant is never revoked)
  // ---------------------------------------------------------------------------
  assign store_blk = (cnt_reg == MAX_CNT);
`ifdef MLSU_ARB_LDST_ORDER_EN
  assign load_blk  = (cnt_reg != '0);
`else
  assign load_blk  = 1'b0;
`endif

  for (genvar gi = 0; gi < NrReq; gi++) begin : g_elig
    assign elig[gi] = req_valid_i[gi] &
                      ~(req_is_store_i[gi] ? store_blk : load_blk);
  end

  mlsu_rr_picker #(
    .NrReq (NrReq),
    .IdW   (IdW)
  ) u_picker (
    .elig  (elig),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .idx   (winner)
  );

  // ---------------------------------------------------------------------------
  // FSM next-state and grant selection
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    lock_next  = lock_reg;
    grant_vld  = 1'b0;
    grant_id   = winner;
    unique case (state_reg)
      IDLE: begin
        grant_vld = pick_valid;
        if (pick_valid) begin
          if (mlsu_req_ready_i) begin
            ptr_next = IdW'(rr_next_idx(32'(winner), NrReq));
          end else begin
            lock_next  = winner;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        grant_vld = 1'b1;
        grant_id  = lock_reg;
        if (mlsu_req_ready_i) begin
          ptr_next   = IdW'(rr_next_idx(32'(lock_reg), NrReq));
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Reset gates the request path directly so a held grant disappears at once.
  assign mlsu_req_valid_o = grant_vld & ~rst_i;
  assign handshake        = mlsu_req_valid_o & mlsu_req_ready_i;
  assign mlsu_req_id_o    = mlsu_req_valid_o ? grant_id : '0;
  assign mlsu_req_o       = mlsu_req_valid_o ? req_i[grant_id] : '0;

  for (genvar gi = 0; gi < NrReq; gi++) begin : g_ready
    assign req_ready_o[gi] = handshake & (grant_id == IdW'(gi));
  end

  // ---------------------------------------------------------------------------
  // Outstanding store counter. A done pulse with nothing outstanding is
  // ignored; an increment and decrement together cancel.
  // ---------------------------------------------------------------------------
  assign st_inc = handshake & req_is_store_i[grant_id];
  assign st_dec = st_done_i & (cnt_reg != '0);

  always_comb begin
    cnt_next = cnt_reg;
    if (st_inc && !st_dec && (cnt_reg != MAX_CNT)) begin
      cnt_next = cnt_reg + CntW'(1);
    end else if (!st_inc && st_dec) begin
      cnt_next = cnt_reg - CntW'(1);
    end
  end

  assign st_pending_o   = (cnt_reg != '0);
  assign st_outst_cnt_o = cnt_reg;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      lock_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      lock_reg  <= lock_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_mlsu_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mlsu_req_arbiter
//   Directed self-checking bench for mlsu_req_arbiter (NrReq=2, MaxStOutst=4,
//   8-bit payload). Inputs change 1 time unit after the rising edge; outputs
//   are sampled 1 time unit later. Expectations follow the
//   MLSU_ARB_LDST_ORDER_EN build option where it matters.
// -----------------------------------------------------------------------------
module tb_mlsu_req_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [7:0] req [2];
  logic [1:0] req_is_store = '0;
  logic       mlsu_req_valid;
  logic       mlsu_req_ready = 1'b0;
  logic [7:0] mlsu_req;
  logic [0:0] mlsu_req_id;
  logic       st_done = 1'b0;
  logic       st_pending;
  logic [2:0] st_outst_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mlsu_req_arbiter #(
    .NrReq           (2),
    .MaxStOutst      (4),
    .mlsu_init_req_t (logic [7:0])
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_i            (req),
    .req_is_store_i   (req_is_store),
    .mlsu_req_valid_o (mlsu_req_valid),
    .mlsu_req_ready_i (mlsu_req_ready),
    .mlsu_req_o       (mlsu_req),
    .mlsu_req_id_o    (mlsu_req_id),
    .st_done_i        (st_done),
    .st_pending_o     (st_pending),
    .st_outst_cnt_o   (st_outst_cnt)
  );

  // Protocol monitors: a held requester must keep valid; no done pulse
  // without an outstanding store.
  logic       hold_q    = 1'b0;
  logic [0:0] hold_id_q = '0;
  always @(posedge clk) begin
    if (!rst && hold_q) begin
      assert (req_valid[hold_id_q])
        else $error("protocol: requester %0d dropped valid while held", hold_id_q);
    end
    if (!rst && st_done) begin
      assert (st_outst_cnt != 3'd0)
        else $error("protocol: st_done_i with no outstanding store");
    end
    hold_q    <= mlsu_req_valid && !mlsu_req_ready && !rst;
    hold_id_q <= mlsu_req_id;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Checks the request-side view; id/payload only matter while valid.
  task automatic grant(input string tag, input logic v, input logic [0:0] id,
                       input logic [7:0] pay, input logic [1:0] rdy);
    check({tag, "_valid"}, 32'(mlsu_req_valid), 32'(v));
    check({tag, "_ready"}, 32'(req_ready), 32'(rdy));
    if (v) begin
      check({tag, "_id"},  32'(mlsu_req_id), 32'(id));
      check({tag, "_pay"}, 32'(mlsu_req), 32'(pay));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:0] eid;
    req[0] = '0;
    req[1] = '0;

    // ---------------- reset values (request present during reset) ----------
    rst       = 1'b1;
    req_valid = 2'b11;
    tick();
    tick();
    #1;
    check("rst_valid", 32'(mlsu_req_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_id",    32'(mlsu_req_id), 32'd0);
    check("rst_pay",   32'(mlsu_req), 32'd0);
    check("rst_pend",  32'(st_pending), 32'd0);
    check("rst_cnt",   32'(st_outst_cnt), 32'd0);
    req_valid = 2'b00;
    tick();
    rst = 1'b0;

    // ---------------- round robin, both loads valid, ready high -------------
    req[0]         = 8'hA0;
    req[1]         = 8'hA1;
    req_is_store   = 2'b00;
    req_valid      = 2'b11;
    mlsu_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      eid = k[0];
      #1 grant("rr", 1'b1, eid, eid ? 8'hA1 : 8'hA0, eid ? 2'b10 : 2'b01);
      tick();
    end
    req_valid = 2'b00;

    // ---------------- hold: requester 1 locked while ready low -------------
    req_valid      = 2'b10;
    req[1]         = 8'h5B;
    mlsu_req_ready = 1'b0;
    #1 grant("hold0", 1'b1, 1'b1, 8'h5B, 2'b00);
    tick();
    req_valid = 2'b11;
    #1 grant("hold1", 1'b1, 1'b1, 8'h5B, 2'b00);
    tick();
    #1 grant("hold2", 1'b1, 1'b1, 8'h5B, 2'b00);
    tick();
    mlsu_req_ready = 1'b1;
    #1 grant("hold_rel", 1'b1, 1'b1, 8'h5B, 2'b10);
    tick();
    req_valid = 2'b01;
    #1 grant("after_hold", 1'b1, 1'b0, 8'hA0, 2'b01);
    tick();
    req_valid = 2'b00;

    // ---------------- store limit: 4 accepted, 5th stalls -------------------
    req_is_store = 2'b01;
    req[0]       = 8'h50;
    req_valid    = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1 grant("st_acc", 1'b1, 1'b0, 8'h50, 2'b01);
      check("st_acc_cnt", 32'(st_outst_cnt), 32'(k));
      tick();
    end
    #1 grant("st_full", 1'b0, 1'b0, 8'h00, 2'b00);
    check("st_full_cnt",  32'(st_outst_cnt), 32'd4);
    check("st_full_pend", 32'(st_pending), 32'd1);
    tick();
    #1 grant("st_full2", 1'b0, 1'b0, 8'h00, 2'b00);
    tick();
    st_done = 1'b1;
    #1 grant("st_done_cyc", 1'b0, 1'b0, 8'h00, 2'b00);
    check("st_done_cyc_cnt", 32'(st_outst_cnt), 32'd4);
    tick();
    st_done = 1'b0;
    #1 grant("st_5th", 1'b1, 1'b0, 8'h50, 2'b01);
    check("st_5th_cnt", 32'(st_outst_cnt), 32'd3);
    tick();
    req_valid = 2'b00;
    #1 check("st_refill_cnt", 32'(st_outst_cnt), 32'd4);

    // ---------------- inc and dec in the same cycle -------------------------
    st_done = 1'b1;
    tick();
    tick();
    st_done = 1'b0;
    #1 check("drain_cnt", 32'(st_outst_cnt), 32'd2);
    req_valid = 2'b01;
    st_done   = 1'b1;
    #1 grant("st_both", 1'b1, 1'b0, 8'h50, 2'b01);
    tick();
    st_done   = 1'b0;
    req_valid = 2'b00;
    #1 check("st_both_cnt", 32'(st_outst_cnt), 32'd2);
    st_done = 1'b1;
    tick();
    st_done = 1'b0;
    #1 check("cnt_one", 32'(st_outst_cnt), 32'd1);
    check("cnt_one_pend", 32'(st_pending), 32'd1);

    // ---------------- load with one store outstanding -----------------------
    req_is_store = 2'b00;
    req[1]       = 8'h71;
    req_valid    = 2'b10;
`ifdef MLSU_ARB_LDST_ORDER_EN
    #1 grant("ld_block", 1'b0, 1'b0, 8'h00, 2'b00);
    tick();
    st_done = 1'b1;
    #1 grant("ld_block_done", 1'b0, 1'b0, 8'h00, 2'b00);
    tick();
    st_done = 1'b0;
    #1 grant("ld_go", 1'b1, 1'b1, 8'h71, 2'b10);
    check("ld_go_cnt", 32'(st_outst_cnt), 32'd0);
    tick();
    req_valid = 2'b00;
`else
    #1 grant("ld_go", 1'b1, 1'b1, 8'h71, 2'b10);
    check("ld_go_cnt", 32'(st_outst_cnt), 32'd1);
    tick();
    req_valid = 2'b00;
    st_done   = 1'b1;
    tick();
    st_done = 1'b0;
`endif
    #1 check("ld_end_cnt", 32'(st_outst_cnt), 32'd0);
    check("ld_end_pend", 32'(st_pending), 32'd0);

    // ---------------- reset during HOLD ------------------------------------
    req_is_store   = 2'b11;
    req[0]         = 8'h60;
    req[1]         = 8'h61;
    req_valid      = 2'b01;
    mlsu_req_ready = 1'b1;
    #1 grant("rs_st0", 1'b1, 1'b0, 8'h60, 2'b01);
    tick();
    req_valid      = 2'b10;
    mlsu_req_ready = 1'b0;
    #1 grant("rs_lock", 1'b1, 1'b1, 8'h61, 2'b00);
    check("rs_lock_cnt", 32'(st_outst_cnt), 32'd1);
    tick();
    #1 grant("rs_hold", 1'b1, 1'b1, 8'h61, 2'b00);
    rst = 1'b1;
    #1 grant("rs_async", 1'b0, 1'b0, 8'h00, 2'b00);
    check("rs_async_cnt",  32'(st_outst_cnt), 32'd0);
    check("rs_async_pend", 32'(st_pending), 32'd0);
    req_valid = 2'b00;
    tick();
    tick();
    rst            = 1'b0;
    req_is_store   = 2'b00;
    req[0]         = 8'hA0;
    req[1]         = 8'hA1;
    req_valid      = 2'b11;
    mlsu_req_ready = 1'b1;
    #1 grant("rs_ptr", 1'b1, 1'b0, 8'hA0, 2'b01);
    check("rs_ptr_cnt", 32'(st_outst_cnt), 32'd0);
    tick();
    req_valid = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
